npuarc_biu_ibp_err_slv: RTL and testbench



---
 rtl/npuarc_biu_ibp_err_slv.sv | 130 +++++++++++++
 tb/tb_npuarc_biu_ibp_err_slv.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/npuarc_biu_ibp_err_slv.sv
// IBP default/error target: ends every command to unmapped space with error responses.
// Optional NPUARC_BIU_ERR_SLV_RDATA_PATTERN_EN puts a 0xDEADBEEF^beat_cnt marker on error read data.
module npuarc_biu_ibp_err_slv #(
  parameter int unsigned CMD_CHNL_READ           = 0,
  parameter int unsigned CMD_CHNL_BURST_SIZE_LSB = 5,
  parameter int unsigned CMD_CHNL_BURST_SIZE_W   = 4,
  parameter int unsigned CMD_CHNL_W              = 49,
  parameter int unsigned WD_CHNL_LAST            = 0,
  parameter int unsigned WD_CHNL_W               = 37,
  parameter int unsigned RD_CHNL_ERR_RD          = 0,
  parameter int unsigned RD_CHNL_RD_LAST         = 1,
  parameter int unsigned RD_CHNL_RD_EXCL_OK      = 2,
  parameter int unsigned RD_CHNL_RD_DATA_LSB     = 3,
  parameter int unsigned RD_CHNL_RD_DATA_W       = 32,
  parameter int unsigned RD_CHNL_W               = 35,
  parameter int unsigned WRSP_CHNL_WR_DONE       = 0,
  parameter int unsigned WRSP_CHNL_WR_EXCL_DONE  = 1,
  parameter int unsigned WRSP_CHNL_ERR_WR        = 2,
  parameter int unsigned WRSP_CHNL_W             = 3
) (
  input  logic                   clk,
  input  logic                   rst_a,
  input  logic                   nmi_restart_r,
  input  logic                   ibp_cmd_chnl_valid,
  output logic                   ibp_cmd_chnl_accept,
  input  logic [CMD_CHNL_W-1:0]  ibp_cmd_chnl,
  input  logic                   ibp_wd_chnl_valid,
  output logic                   ibp_wd_chnl_accept,
  input  logic [WD_CHNL_W-1:0]   ibp_wd_chnl,
  output logic                   ibp_rd_chnl_valid,
  input  logic                   ibp_rd_chnl_accept,
  output logic [RD_CHNL_W-1:0]   ibp_rd_chnl,
  output logic                   ibp_wrsp_chnl_valid,
  input  logic                   ibp_wrsp_chnl_accept,
  output logic [WRSP_CHNL_W-1:0] ibp_wrsp_chnl,
  output logic                   ibp_idle
);

  localparam int unsigned BW = CMD_CHNL_BURST_SIZE_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WD,
    ST_WRSP
  } state_t;

  state_t          state_q;
  logic [BW-1:0]   beat_cnt_q;
  logic [RD_CHNL_RD_DATA_W-1:0] rd_data;

  // Only the read flag, burst size and wd last bit matter; everything else is dropped.
  logic unused_payload;
  assign unused_payload = ^{ibp_cmd_chnl, ibp_wd_chnl};

  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      state_q    <= ST_IDLE;
      beat_cnt_q <= '0;
    end else if (nmi_restart_r) begin
      state_q    <= ST_IDLE;
      beat_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ibp_cmd_chnl_valid) begin
            if (ibp_cmd_chnl[CMD_CHNL_READ]) begin
              state_q    <= ST_RD;
              beat_cnt_q <= ibp_cmd_chnl[CMD_CHNL_BURST_SIZE_LSB +: BW];
            end else begin
              state_q    <= ST_WD;
            end
          end
        end
        ST_RD: begin
          if (ibp_rd_chnl_accept) begin
            if (beat_cnt_q == '0) begin
              state_q <= ST_IDLE;
            end else begin
              beat_cnt_q <= beat_cnt_q - BW'(1);
            end
          end
        end
        ST_WD: begin
          if (ibp_wd_chnl_valid && ibp_wd_chnl[WD_CHNL_LAST]) begin
            state_q <= ST_WRSP;
          end
        end
        ST_WRSP: begin
          if (ibp_wrsp_chnl_accept) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef NPUARC_BIU_ERR_SLV_RDATA_PATTERN_EN
  localparam int unsigned PAT_REPS = (RD_CHNL_RD_DATA_W + 31) / 32;
  localparam logic [PAT_REPS*32-1:0] PAT_REP = {PAT_REPS{32'hDEAD_BEEF}};
  assign rd_data = PAT_REP[RD_CHNL_RD_DATA_W-1:0] ^ RD_CHNL_RD_DATA_W'(beat_cnt_q);
`else
  assign rd_data = '0;
`endif

  assign ibp_idle            = (state_q == ST_IDLE);
  assign ibp_cmd_chnl_accept = (state_q == ST_IDLE);
  assign ibp_wd_chnl_accept  = (state_q == ST_WD);
  assign ibp_rd_chnl_valid   = (state_q == ST_RD);
  assign ibp_wrsp_chnl_valid = (state_q == ST_WRSP);

  always_comb begin
    ibp_rd_chnl = '0;
    if (state_q == ST_RD) begin
      ibp_rd_chnl[RD_CHNL_ERR_RD]     = 1'b1;
      ibp_rd_chnl[RD_CHNL_RD_LAST]    = (beat_cnt_q == '0);
      ibp_rd_chnl[RD_CHNL_RD_EXCL_OK] = 1'b0;
      ibp_rd_chnl[RD_CHNL_RD_DATA_LSB +: RD_CHNL_RD_DATA_W] = rd_data;
    end
  end

  always_comb begin
    ibp_wrsp_chnl = '0;
    ibp_wrsp_chnl[WRSP_CHNL_WR_DONE]      = 1'b0;
    ibp_wrsp_chnl[WRSP_CHNL_WR_EXCL_DONE] = 1'b0;
    ibp_wrsp_chnl[WRSP_CHNL_ERR_WR]       = (state_q == ST_WRSP);
  end

endmodule

// File: tb/tb_npuarc_biu_ibp_err_slv.sv
// Bench for npuarc_biu_ibp_err_slv: directed table, corner sequences, random traffic vs a transaction model.
module tb_npuarc_biu_ibp_err_slv;
  localparam int CW = 49;
  localparam int WW = 37;
  localparam int RW = 35;

  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic nmi = 1'b0;
  logic cv = 1'b0;
  logic [CW-1:0] cmd = '0;
  logic wv = 1'b0;
  logic [WW-1:0] wd = '0;
  logic ra = 1'b0;
  logic wa = 1'b0;
  logic cacc, wacc, rv, wsv, idle;
  logic [RW-1:0] rd_chnl;
  logic [2:0] wsp_chnl;

  npuarc_biu_ibp_err_slv dut (
    .clk(clk), .rst_a(rst_a), .nmi_restart_r(nmi),
    .ibp_cmd_chnl_valid(cv), .ibp_cmd_chnl_accept(cacc), .ibp_cmd_chnl(cmd),
    .ibp_wd_chnl_valid(wv), .ibp_wd_chnl_accept(wacc), .ibp_wd_chnl(wd),
    .ibp_rd_chnl_valid(rv), .ibp_rd_chnl_accept(ra), .ibp_rd_chnl(rd_chnl),
    .ibp_wrsp_chnl_valid(wsv), .ibp_wrsp_chnl_accept(wa), .ibp_wrsp_chnl(wsp_chnl),
    .ibp_idle(idle)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  // Transaction-level reference: read beats still owed, open write burst, pending response.
  int m_rd_left = 0;
  bit m_wr_open = 1'b0;
  bit m_rsp = 1'b0;

  function automatic bit m_idle();
    return (m_rd_left == 0) && !m_wr_open && !m_rsp;
  endfunction

  always @(posedge clk or negedge rst_a) begin
    if (!rst_a || nmi) begin
      m_rd_left = 0;
      m_wr_open = 1'b0;
      m_rsp = 1'b0;
    end else if (m_idle()) begin
      if (cv) begin
        if (cmd[0]) m_rd_left = int'(cmd[8:5]) + 1;
        else m_wr_open = 1'b1;
      end
    end else if (m_rd_left > 0) begin
      if (ra) m_rd_left = m_rd_left - 1;
    end else if (m_wr_open) begin
      if (wv && wd[0]) begin
        m_wr_open = 1'b0;
        m_rsp = 1'b1;
      end
    end else if (wa) begin
      m_rsp = 1'b0;
    end
  end

  function automatic logic [31:0] exp_data(input int beats_left);
`ifdef NPUARC_BIU_ERR_SLV_RDATA_PATTERN_EN
    return 32'hDEAD_BEEF ^ 32'(beats_left - 1);
`else
    return (beats_left > 0) ? 32'h0 : 32'h0;
`endif
  endfunction

  function automatic logic [63:0] m_obs();
    logic [RW-1:0] r;
    r = '0;
    if (m_rd_left > 0) begin
      r[0] = 1'b1;
      r[1] = (m_rd_left == 1);
      r[34:3] = exp_data(m_rd_left);
    end
    return 64'({m_idle(), m_idle(), m_wr_open, (m_rd_left > 0), r, m_rsp, m_rsp, 1'b0, 1'b0});
  endfunction

  function automatic logic [63:0] dut_obs();
    return 64'({idle, cacc, wacc, rv, rd_chnl, wsv, wsp_chnl});
  endfunction

  always @(negedge clk) begin
    #3;
    if (chk_en) check("model", dut_obs(), m_obs());
  end

  // {nmi, cv, rd, bs[3:0], wv, wl, ra, wa} and expected {cacc, rv, rl, wacc, wsv, idle} after the edge
  typedef struct packed {
    logic       nmi, cv, rd;
    logic [3:0] bs;
    logic       wv, wl, ra, wa;
    logic [5:0] e;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic [10:0] in, input logic [5:0] e);
    tbl.push_back({in, e});
  endtask

  task automatic drive(input logic n, input logic c, input logic r, input logic [3:0] b,
                       input logic w, input logic l, input logic a, input logic s);
    nmi = n; cv = c; ra = a; wa = s; wv = w;
    cmd = '0; cmd[0] = r; cmd[8:5] = b;
    wd = '0; wd[0] = l;
  endtask

  initial begin
    logic [42:0] rst_exp;
    rst_exp = {1'b1, 1'b1, 1'b0, 1'b0, 35'b0, 1'b0, 3'b0};
    repeat (2) @(negedge clk);
    #1 check("reset_state", dut_obs(), 64'(rst_exp));
    @(negedge clk);
    rst_a = 1'b1;
    chk_en = 1'b1;

    // burst_size=3 read with a write command waiting behind it
    add(11'b0_1_1_0011_0_0_1_0, 6'b010000);
    add(11'b0_1_0_0000_0_0_1_0, 6'b010000);
    add(11'b0_1_0_0000_1_1_1_0, 6'b010000);
    add(11'b0_1_0_0000_0_0_1_0, 6'b011000);
    add(11'b0_1_0_0000_0_0_1_0, 6'b100001);
    add(11'b0_1_0_0000_0_0_0_0, 6'b000100);
    // four write beats with 2-cycle gaps, last on the fourth
    for (int i = 0; i < 4; i++) begin
      add({7'b0_0_0_0000, 1'b1, (i == 3), 2'b00}, (i == 3) ? 6'b000010 : 6'b000100);
      if (i < 3) begin
        add(11'b0, 6'b000100);
        add(11'b0, 6'b000100);
      end
    end
    add(11'b0, 6'b000010);
    add(11'b0, 6'b000010);
    add(11'b0_0_0_0000_0_0_0_1, 6'b100001);
    // single-beat read stalled five cycles
    add(11'b0_1_1_0000_0_0_0_0, 6'b011000);
    for (int i = 0; i < 5; i++) add(11'b0, 6'b011000);
    add(11'b0_0_0_0000_0_0_1_0, 6'b100001);
    // 8-beat read, restart on beat 2 overrides the accept and a new command
    add(11'b0_1_1_0111_0_0_1_0, 6'b010000);
    add(11'b0_0_0_0000_0_0_1_0, 6'b010000);
    add(11'b1_1_1_0010_0_0_1_0, 6'b100001);
    add(11'b0, 6'b100001);

    foreach (tbl[k]) begin
      drive(tbl[k].nmi, tbl[k].cv, tbl[k].rd, tbl[k].bs, tbl[k].wv, tbl[k].wl, tbl[k].ra, tbl[k].wa);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", k), 64'({cacc, rv, rd_chnl[1], wacc, wsv, idle}), 64'(tbl[k].e));
      check($sformatf("vec%0d_err", k), 64'({rd_chnl[0], wsp_chnl}), 64'({tbl[k].e[4], tbl[k].e[1], 2'b00}));
      @(negedge clk);
    end

    // asynchronous reset while in WD: no response may follow
    drive(0, 1, 0, 4'd0, 0, 0, 0, 0);
    @(posedge clk);
    #1 check("wd_entered", 64'({wacc, idle}), 64'(2'b10));
    @(negedge clk);
    drive(0, 0, 0, 4'd0, 1, 1, 0, 0);
    rst_a = 1'b0;
    #1 check("async_rst", 64'({idle, cacc, wacc, wsv}), 64'(4'b1100));
    @(posedge clk);
    #1 check("rst_no_wrsp", 64'({wsv, idle}), 64'(2'b01));
    @(negedge clk);
    rst_a = 1'b1;
    drive(0, 0, 0, 4'd0, 0, 0, 0, 0);
    @(posedge clk);
    #1 check("rst_release", 64'({idle, wsv}), 64'(2'b10));
    @(negedge clk);

    // two-beat read data values
    drive(0, 1, 1, 4'd1, 0, 0, 1, 0);
    @(posedge clk);
    #1 check("rdata_beat0", 64'(rd_chnl[34:3]), 64'(exp_data(2)));
    @(negedge clk);
    cv = 1'b0;
    @(posedge clk);
    #1 check("rdata_beat1", 64'({rd_chnl[1], rd_chnl[34:3]}), 64'({1'b1, exp_data(1)}));
    @(negedge clk);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst_a = ($urandom_range(0, 255) != 0);
      nmi = ($urandom_range(0, 63) == 0);
      cv = ($urandom_range(0, 2) == 0);
      cmd = {17'($urandom), $urandom};
      wv = $urandom_range(0, 1) == 1;
      wd = {5'($urandom), $urandom};
      if ($urandom_range(0, 2) != 0) wd[0] = 1'b0;
      ra = ($urandom_range(0, 3) != 0);
      wa = ($urandom_range(0, 2) == 0);
      @(negedge clk);
    end

    rst_a = 1'b1;
    drive(0, 0, 0, 4'd0, 1, 1, 1, 1);
    repeat (20) @(negedge clk);
    #4 check("drain_idle", 64'(idle), 64'(1'b1));
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
